fejkon_fc_stats: RTL and testbench

Per-channel Fibre Channel frame statistics stage on the 256-bit Avalon-ST FC path. It sits directly downstream of the FC debug stage and consumes its stream. Every beat is forwarded unchanged through a two-entry skid buffer, while frames, bytes and framing errors are counted per channel. Counters are exposed on a CSR port.

---
 rtl/fejkon_fc_stats_pkg.sv | 38 +++
 rtl/fejkon_st_skid.sv | 80 ++++++++
 rtl/fejkon_fc_stats.sv | 172 +++++++++++++++++
 tb/tb_fejkon_fc_stats.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fejkon_fc_stats_pkg.sv
// rtl/fejkon_fc_stats_pkg.sv - shared constants and beat layout for the FC statistics stage
//
// Purpose: CSR register indices, control address, beat geometry and counter
// widths used by fejkon_fc_stats and its testbench-facing CSR map.
package fejkon_fc_stats_pkg;

  localparam int unsigned BEAT_BYTES  = 32;
  localparam int unsigned CNT_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH  = 256;
  localparam int unsigned CHAN_WIDTH  = 4;
  localparam int unsigned EMPTY_WIDTH = 5;

  // Register index within a channel's 4-word CSR window (address[1:0]).
  localparam logic [1:0] FRAMES = 2'd0;
  localparam logic [1:0] BYTES  = 2'd1;
  localparam logic [1:0] ERRORS = 2'd2;
  localparam logic [1:0] STATUS = 2'd3;

  // Control/status word: read = bad_chan, write bit0 = clear all.
  localparam logic [7:0] CTRL_ADDR = 8'h40;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [CHAN_WIDTH-1:0]  channel;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } fc_beat_t;

  localparam int unsigned BEAT_WIDTH = $bits(fc_beat_t);

  // Valid payload bytes carried by one beat; empty only applies on EOP.
  function automatic logic [CNT_WIDTH-1:0] beat_bytes(input logic eop,
                                                      input logic [EMPTY_WIDTH-1:0] empty);
    return eop ? (CNT_WIDTH'(BEAT_BYTES) - CNT_WIDTH'(empty)) : CNT_WIDTH'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/fejkon_st_skid.sv
// rtl/fejkon_st_skid.sv - generic two-entry Avalon-ST skid buffer
//
// Purpose: registered pass-through of an opaque payload with full throughput
// and a registered ready.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   in_data_i/valid_i     sink payload and valid; in_ready_o registered ready
//   out_data_o/valid_o    source payload and valid; out_ready_i source ready
module fejkon_st_skid #(
  parameter int unsigned WIDTH = 267
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             accept, out_free;

  always_comb begin
    accept       = in_valid_i && ready_q;
    out_free     = !out_valid_q || out_ready_i;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (out_free) begin
      // ready_q is low whenever the skid holds a beat, so a refill from the
      // skid never coincides with a new acceptance.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end

    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/fejkon_fc_stats.sv
// rtl/fejkon_fc_stats.sv - per-channel FC frame/byte/error statistics on the 256-bit stream
//
// Purpose: forwards every beat unchanged through a skid buffer and counts
// frames, bytes and framing errors per channel, exposed on a CSR port.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   st_in_*              Avalon-ST sink (data/channel/sop/eop/empty/valid, ready out)
//   st_out_*             Avalon-ST source, copies of accepted input beats
//   csr_*                word-addressed CSR port, read latency 1
module fejkon_fc_stats
  import fejkon_fc_stats_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] st_in_data,
  input  logic [3:0]   st_in_channel,
  input  logic         st_in_startofpacket,
  input  logic         st_in_endofpacket,
  input  logic [4:0]   st_in_empty,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  output logic [255:0] st_out_data,
  output logic [3:0]   st_out_channel,
  output logic         st_out_startofpacket,
  output logic         st_out_endofpacket,
  output logic [4:0]   st_out_empty,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  input  logic [7:0]   csr_address,
  input  logic         csr_read,
  input  logic         csr_write,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata
);

  fc_beat_t in_beat, out_beat;

  assign in_beat = '{data:    st_in_data,
                     channel: st_in_channel,
                     sop:     st_in_startofpacket,
                     eop:     st_in_endofpacket,
                     empty:   st_in_empty};

  fejkon_st_skid #(
    .WIDTH (BEAT_WIDTH)
  ) u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_data_i   (in_beat),
    .in_valid_i  (st_in_valid),
    .in_ready_o  (st_in_ready),
    .out_data_o  (out_beat),
    .out_valid_o (st_out_valid),
    .out_ready_i (st_out_ready)
  );

  assign st_out_data          = out_beat.data;
  assign st_out_channel       = out_beat.channel;
  assign st_out_startofpacket = out_beat.sop;
  assign st_out_endofpacket   = out_beat.eop;
  assign st_out_empty         = out_beat.empty;

  logic [CNT_WIDTH-1:0]    frames_q  [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    frames_d  [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    bytes_q   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    bytes_d   [NUM_CHANNELS];
  logic [ERR_WIDTH-1:0]    errors_q  [NUM_CHANNELS];
  logic [ERR_WIDTH-1:0]    errors_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] in_packet_q, in_packet_d;
  logic [CNT_WIDTH-1:0]    bad_chan_q, bad_chan_d;
  logic [31:0]             readdata_q, readdata_d;

  logic accept, clear, chan_ok, ip, frame_err;

  assign accept  = st_in_valid && st_in_ready;
  assign clear   = csr_write && (csr_address == CTRL_ADDR) && csr_writedata[0];
  assign chan_ok = {28'd0, st_in_channel} < NUM_CHANNELS;

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata[31:1];

  always_comb begin
    frames_d    = frames_q;
    bytes_d     = bytes_q;
    errors_d    = errors_q;
    in_packet_d = in_packet_q;
    bad_chan_d  = bad_chan_q;
    ip          = 1'b0;
    frame_err   = 1'b0;

    // A clear in the same cycle as an accepted beat wins; the beat is dropped
    // from the statistics but still forwarded.
    if (clear) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        frames_d[c] = '0;
        bytes_d[c]  = '0;
        errors_d[c] = '0;
      end
      in_packet_d = '0;
      bad_chan_d  = '0;
    end else if (accept) begin
      if (!chan_ok && (bad_chan_q != {CNT_WIDTH{1'b1}})) begin
        bad_chan_d = bad_chan_q + CNT_WIDTH'(1);
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (st_in_channel == CHAN_WIDTH'(c)) begin
          ip = in_packet_q[c];
          bytes_d[c] = bytes_q[c] + beat_bytes(st_in_endofpacket, st_in_empty);
          if (st_in_endofpacket && (ip || st_in_startofpacket)) begin
            frames_d[c] = frames_q[c] + CNT_WIDTH'(1);
          end
          // Restarted frame (SOP inside a frame) or orphan beat outside one.
          frame_err = (st_in_startofpacket && ip) || (!st_in_startofpacket && !ip);
          if (frame_err && (errors_q[c] != {ERR_WIDTH{1'b1}})) begin
            errors_d[c] = errors_q[c] + ERR_WIDTH'(1);
          end
          if (st_in_endofpacket) begin
            in_packet_d[c] = 1'b0;
          end else if (st_in_startofpacket) begin
            in_packet_d[c] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    if (csr_address == CTRL_ADDR) begin
      readdata_d = bad_chan_q;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (csr_address[7:2] == 6'(c)) begin
        case (csr_address[1:0])
          FRAMES:  readdata_d = frames_q[c];
          BYTES:   readdata_d = bytes_q[c];
          ERRORS:  readdata_d = 32'(errors_q[c]);
          STATUS:  readdata_d = {31'd0, in_packet_q[c]};
          default: readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        frames_q[c] <= '0;
        bytes_q[c]  <= '0;
        errors_q[c] <= '0;
      end
      in_packet_q <= '0;
      bad_chan_q  <= '0;
      readdata_q  <= '0;
    end else begin
      frames_q    <= frames_d;
      bytes_q     <= bytes_d;
      errors_q    <= errors_d;
      in_packet_q <= in_packet_d;
      bad_chan_q  <= bad_chan_d;
      if (csr_read) begin
        readdata_q <= readdata_d;
      end
    end
  end

  assign csr_readdata = readdata_q;

endmodule

// File: tb/tb_fejkon_fc_stats.sv
// tb/tb_fejkon_fc_stats.sv - self-checking bench for fejkon_fc_stats
module tb_fejkon_fc_stats;

  localparam int NCH     = 4;
  localparam int ERR_MAX = 65535;

  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   ch;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] st_in_data;
  logic [3:0]   st_in_channel;
  logic         st_in_startofpacket, st_in_endofpacket;
  logic [4:0]   st_in_empty;
  logic         st_in_valid, st_in_ready;
  logic [255:0] st_out_data;
  logic [3:0]   st_out_channel;
  logic         st_out_startofpacket, st_out_endofpacket;
  logic [4:0]   st_out_empty;
  logic         st_out_valid, st_out_ready;
  logic [7:0]   csr_address;
  logic         csr_read, csr_write;
  logic [31:0]  csr_writedata, csr_readdata;

  int checks   = 0;
  int failures = 0;

  beat_t       exp_q[$];
  logic [31:0] m_frames[16];
  logic [31:0] m_bytes[16];
  logic [31:0] m_err[16];
  logic [31:0] m_bad;
  bit          m_inpkt[16];
  bit          rst_last;
  bit          toggle_ready;

  always #5 clk = ~clk;

  fejkon_fc_stats #(.NUM_CHANNELS(NCH), .ERR_WIDTH(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .st_in_data           (st_in_data),
    .st_in_channel        (st_in_channel),
    .st_in_startofpacket  (st_in_startofpacket),
    .st_in_endofpacket    (st_in_endofpacket),
    .st_in_empty          (st_in_empty),
    .st_in_valid          (st_in_valid),
    .st_in_ready          (st_in_ready),
    .st_out_data          (st_out_data),
    .st_out_channel       (st_out_channel),
    .st_out_startofpacket (st_out_startofpacket),
    .st_out_endofpacket   (st_out_endofpacket),
    .st_out_empty         (st_out_empty),
    .st_out_valid         (st_out_valid),
    .st_out_ready         (st_out_ready),
    .csr_address          (csr_address),
    .csr_read             (csr_read),
    .csr_write            (csr_write),
    .csr_writedata        (csr_writedata),
    .csr_readdata         (csr_readdata)
  );

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 16; c++) begin
      m_frames[c] = 0; m_bytes[c] = 0; m_err[c] = 0; m_inpkt[c] = 0;
    end
    m_bad = 0;
  endtask

  task automatic model_count(input beat_t b);
    int c;
    c = int'(b.ch);
    if (c >= NCH) begin
      if (m_bad != 32'hFFFF_FFFF) m_bad = m_bad + 1;
    end else begin
      m_bytes[c] = m_bytes[c] + (b.eop ? 32 - int'(b.empty) : 32);
      if (b.eop && (m_inpkt[c] || b.sop)) m_frames[c] = m_frames[c] + 1;
      if ((b.sop && m_inpkt[c]) || (!b.sop && !m_inpkt[c]))
        if (m_err[c] < ERR_MAX) m_err[c] = m_err[c] + 1;
      if (b.eop) m_inpkt[c] = 0;
      else if (b.sop) m_inpkt[c] = 1;
    end
  endtask

  // One clock: check handshake state, score the outgoing beat, advance the model.
  task automatic cycle();
    bit acc, xfer, clr;
    beat_t b, cur;
    chk("in_ready", st_in_ready, !rst_last && exp_q.size() < 2);
    chk("out_valid", st_out_valid, exp_q.size() != 0);
    acc  = st_in_valid && st_in_ready && !reset;
    xfer = st_out_valid && st_out_ready && !reset;
    clr  = csr_write && csr_address == 8'h40 && csr_writedata[0];
    cur  = '{st_in_data, st_in_channel, st_in_startofpacket, st_in_endofpacket, st_in_empty};
    if (xfer && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      chk("out_beat", {st_out_data, st_out_channel, st_out_startofpacket,
                       st_out_endofpacket, st_out_empty}, b);
    end
    if (reset) begin
      exp_q.delete();
      model_clear();
    end else begin
      if (acc) exp_q.push_back(cur);
      if (clr) model_clear();
      else if (acc) model_count(cur);
    end
    rst_last = reset;
    @(posedge clk);
    #1;
    if (toggle_ready) st_out_ready = !st_out_ready;
  endtask

  task automatic push_beat(input logic [3:0] ch, input logic sop, input logic eop,
                           input logic [4:0] empty);
    bit got;
    st_in_channel = ch; st_in_startofpacket = sop; st_in_endofpacket = eop;
    st_in_empty = empty; st_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) st_in_data[i*32 +: 32] = $urandom;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = st_in_ready;
      cycle();
    end
    st_in_valid = 1'b0;
    chk("accept", got, 1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    cycle();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_ch(input int c);
    logic [31:0] d;
    rd(8'(c*4+0), d); chk($sformatf("frames%0d", c), d, c < NCH ? m_frames[c] : 0);
    rd(8'(c*4+1), d); chk($sformatf("bytes%0d", c), d, c < NCH ? m_bytes[c] : 0);
    rd(8'(c*4+2), d); chk($sformatf("errors%0d", c), d, c < NCH ? m_err[c] : 0);
    rd(8'(c*4+3), d); chk($sformatf("status%0d", c), d, c < NCH ? 32'(m_inpkt[c]) : 0);
  endtask

  task automatic check_all();
    logic [31:0] d;
    for (int c = 0; c < NCH; c++) check_ch(c);
    rd(8'h40, d); chk("bad_chan", d, m_bad);
    rd(8'h14, d); chk("unmapped_ch5", d, 0);
    rd(8'h41, d); chk("unmapped_41", d, 0);
  endtask

  initial begin
    logic [31:0]  d;
    logic [255:0] saved;
    reset = 1'b1; st_in_valid = 0; st_in_data = '0; st_in_channel = 0;
    st_in_startofpacket = 0; st_in_endofpacket = 0; st_in_empty = 0;
    st_out_ready = 1'b1; csr_address = 0; csr_read = 0; csr_write = 0; csr_writedata = 0;
    toggle_ready = 0;
    model_clear();
    @(posedge clk); #1;
    rst_last = 1;

    // Reset state
    repeat (3) cycle();
    chk("rst_ready", st_in_ready, 0);
    chk("rst_readdata", csr_readdata, 0);
    reset = 1'b0;
    cycle();
    chk("ready_after_reset", st_in_ready, 1);

    // Single-beat frame on ch2
    push_beat(4'd2, 1, 1, 5'd4);
    saved = st_in_data;
    chk("t1_latency", st_out_valid, 1);
    chk("t1_data", st_out_data, saved);
    cycle();
    check_ch(2);
    rd(8'h09, d); chk("t1_bytes28", d, 28);

    // 3-beat frame on ch0 with out_ready toggling
    toggle_ready = 1;
    push_beat(4'd0, 1, 0, 5'd0);
    push_beat(4'd0, 0, 0, 5'd0);
    push_beat(4'd0, 0, 1, 5'd0);
    drain();
    toggle_ready = 0; st_out_ready = 1'b1;
    check_ch(0);
    rd(8'h01, d); chk("t2_bytes96", d, 96);

    // Restarted frame on ch1, orphan beat on ch3
    push_beat(4'd1, 1, 0, 5'd0);
    push_beat(4'd1, 1, 0, 5'd0);
    push_beat(4'd1, 0, 1, 5'd3);
    push_beat(4'd3, 0, 0, 5'd0);
    drain();
    check_ch(1);
    check_ch(3);
    rd(8'h06, d); chk("t3_err1", d, 1);

    // Out-of-range channel
    push_beat(4'd5, 1, 1, 5'd0);
    drain();
    check_all();
    cycle();
    chk("readdata_hold", csr_readdata, 0);

    // Clear coincident with an accepted EOP
    push_beat(4'd0, 1, 0, 5'd0);
    csr_write = 1; csr_address = 8'h40; csr_writedata = 32'h1;
    push_beat(4'd0, 0, 1, 5'd0);
    csr_write = 0;
    drain();
    check_all();
    rd(8'h00, d); chk("t5_frames0_clear", d, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      st_in_valid = $urandom_range(0, 3) != 0;
      st_in_channel = 4'($urandom_range(0, 5));
      st_in_startofpacket = $urandom_range(0, 2) == 0;
      st_in_endofpacket = $urandom_range(0, 2) == 0;
      st_in_empty = 5'($urandom);
      for (int k = 0; k < 8; k++) st_in_data[k*32 +: 32] = $urandom;
      st_out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    st_in_valid = 0; st_out_ready = 1;
    drain();
    check_all();

    // Reset mid-frame with two beats buffered
    st_out_ready = 0;
    push_beat(4'd1, 1, 0, 5'd0);
    push_beat(4'd1, 0, 0, 5'd0);
    chk("t6_buffered", exp_q.size(), 2);
    reset = 1;
    cycle();
    reset = 0;
    chk("t6_out_valid", st_out_valid, 0);
    cycle();
    st_out_ready = 1;
    rd(8'h07, d); chk("t6_status", d, 0);
    push_beat(4'd1, 1, 1, 5'd0);
    drain();
    rd(8'h06, d); chk("t6_err0", d, 0);
    rd(8'h04, d); chk("t6_frames1", d, 1);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
